// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped 2-bit counter table with a BTB.
// Looked up by the IF-stage PC, trained by EX-stage outcomes, with branch/miss statistics.
module branch_predictor #(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_misses
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q [ENTRIES];
    logic [1:0]       cnt_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [3:0]       unused_pc_bits;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != 2'd3)
            nxt = cnt + 2'd1;
        else if (!taken && cnt != 2'd0)
            nxt = cnt - 2'd1;
        return nxt;
    endfunction

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    assign unused_pc_bits = {if_pc[1:0], ex_pc[1:0]};

    // Lookup stage: reads the pre-update table, no bypass from the EX write port
    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_tag      = if_pc[31:IDX_W+2];
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && cnt_q[if_idx][1];
    assign pred_target = if_hit ? tgt_q[if_idx] : seq_pc(if_pc);

    // Resolve stage: compare the travelling prediction against the real outcome
    assign ex_idx      = ex_pc[IDX_W+1:2];
    assign ex_tag      = ex_pc[31:IDX_W+2];
    assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                      (ex_taken && (ex_pred_target != ex_target)));
    assign redirect_pc = ex_taken ? ex_target : seq_pc(ex_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'd1;
            end
        end else if (ex_valid) begin
            if (ex_hit) begin
                cnt_q[ex_idx] <= sat_step(cnt_q[ex_idx], ex_taken);
            end else if (ex_taken) begin
                valid_q[ex_idx] <= 1'b1;
                cnt_q[ex_idx]   <= 2'd2;
            end
        end
    end

    // Tag and target need no reset: a cleared valid bit masks whatever they hold
    always_ff @(posedge clk) begin
        if (ex_valid && ex_taken) begin
            tag_q[ex_idx] <= ex_tag;
            tgt_q[ex_idx] <= ex_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= 32'd0;
            stat_misses   <= 32'd0;
        end else begin
            if (ex_valid)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict)
                stat_misses <= stat_misses + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed plan plus randomized traffic
// checked against a table-of-entries reference model.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'd0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_misses;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_misses(stat_misses)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pt;
        logic [31:0] ptg;
        logic        mp;
        logic [31:0] rpc;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: one record per table slot, counter as a plain integer 0..3
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    longint      m_branches;
    longint      m_misses;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc >> (IDX_W + 2));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
        end
        m_branches = 0;
        m_misses   = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    endtask

    // One cycle of stimulus: drive, record the expected response, then advance the model
    task automatic step(input bit rst, input logic [31:0] ipc, input bit v,
                        input logic [31:0] epc, input bit et, input logic [31:0] etg,
                        input bit ept, input logic [31:0] eptg);
        exp_t e;
        bit   mp;
        int   s;
        @(posedge clk);
        #1;
        rst_n = !rst;
        if_pc = ipc; ex_valid = v; ex_pc = epc; ex_taken = et;
        ex_target = etg; ex_pred_taken = ept; ex_pred_target = eptg;
        if (rst) model_reset();
        mp    = v && ((et != ept) || (et && (eptg != etg)));
        e.pt  = m_hit(ipc) && (m_cnt[slot_of(ipc)] >= 2);
        e.ptg = m_hit(ipc) ? m_tgt[slot_of(ipc)] : ipc + 32'd4;
        e.mp  = mp;
        e.rpc = et ? etg : epc + 32'd4;
        e.sb  = m_branches[31:0];
        e.sm  = m_misses[31:0];
        exp_q.push_back(e);
        if (!rst && v) begin
            s = slot_of(epc);
            m_branches++;
            if (mp) m_misses++;
            if (m_hit(epc)) begin
                m_cnt[s] = et ? ((m_cnt[s] < 3) ? m_cnt[s] + 1 : 3)
                              : ((m_cnt[s] > 0) ? m_cnt[s] - 1 : 0);
                if (et) m_tgt[s] = etg;
            end else if (et) begin
                m_valid[s] = 1'b1;
                m_tag[s]   = tag_of(epc);
                m_cnt[s]   = 2;
                m_tgt[s]   = etg;
            end
        end
    endtask

    task automatic look(input logic [31:0] ipc);
        step(1'b0, ipc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic resolve(input logic [31:0] ipc, input logic [31:0] epc, input bit et,
                           input logic [31:0] etg, input bit ept, input logic [31:0] eptg);
        step(1'b0, ipc, 1'b1, epc, et, etg, ept, eptg);
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 9) == 0) return {$urandom(), 2'b00} & 32'hFFFF_FFFC;
        return 32'h100 * $urandom_range(1, 4) + 32'd4 * $urandom_range(0, 3);
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the update edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
                check("pred_target", pred_target, e.ptg);
                check("mispredict", {31'd0, mispredict}, {31'd0, e.mp});
                if (e.mp) check("redirect_pc", redirect_pc, e.rpc);
                check("stat_branches", stat_branches, e.sb);
                check("stat_misses", stat_misses, e.sm);
            end
        end
    end

    initial begin
        logic [31:0] epc, etg, ptg;
        bit          et, pt;
        int          wait_cycles;
        model_reset();

        step(1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        look(32'h100);
        resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        look(32'h100);
        repeat (3) resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        resolve(32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        look(32'h100);
        resolve(32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        look(32'h100);
        resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        resolve(32'h100, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        look(32'h100);
        resolve(32'h200, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
        look(32'h200);
        look(32'h100);
        resolve(32'h100, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
        look(32'h100);
        look(32'h200);
        step(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h500, 1'b1, 32'h400);
        look(32'h200);
        look(32'h100);

        for (int n = 0; n < 400; n++) begin
            epc = rand_pc();
            et  = $urandom_range(0, 1);
            etg = {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 3) != 0) begin
                pt  = m_hit(epc) && (m_cnt[slot_of(epc)] >= 2);
                ptg = m_hit(epc) ? m_tgt[slot_of(epc)] : epc + 32'd4;
            end else begin
                pt  = $urandom_range(0, 1);
                ptg = {$urandom_range(0, 255), 2'b00};
            end
            step(($urandom_range(0, 59) == 0), rand_pc(), ($urandom_range(0, 3) != 0),
                 epc, et, etg, pt, ptg);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RV32 pipeline: a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB), looked up by the IF-stage PC and trained by the EX-stage branch outcome. It sits on the opposite end of the branch path from the EX-stage comparator. The comparator resolves taken/not-taken late. This block predicts it early, then consumes the resolved outcome to update state and signal mispredictions. It also keeps branch and mispredict performance counters.

## Interface
- ENTRIES, 64, table depth; power of two, 4..1024; IDX_W = log2(ENTRIES).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  32  IF-stage fetch PC (lookup address).
- pred_taken  out  1  prediction for if_pc (combinational).
- pred_target  out  32  predicted target for if_pc (combinational).
- ex_valid  in  1  a conditional branch is resolved in EX this cycle.
- ex_pc  in  32  PC of the resolving branch.
- ex_taken  in  1  resolved outcome (comparator result).
- ex_target  in  32  computed branch target.
- ex_pred_taken  in  1  prediction that travelled down the pipe with this branch.
- ex_pred_target  in  32  predicted target that travelled with this branch.
- mispredict  out  1  flush IF/ID, redirect fetch (combinational).
- redirect_pc  out  32  correct next PC when mispredict=1.
- stat_branches  out  32  resolved-branch count (registered).
- stat_misses  out  32  mispredict count (registered).

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Per entry: valid bit, tag, 2-bit counter, 32-bit target.
- Lookup: hit = valid[idx] && tag match. pred_taken = hit && cnt[idx][1]. pred_target = hit ? target[idx] : if_pc+4.
- mispredict = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target)).
- redirect_pc = ex_taken ? ex_target : ex_pc+4. Value is don't-care when mispredict=0, but it must still be driven deterministically.
- Update at the rising edge when ex_valid=1, entry = index of ex_pc:
  - Tag hit: counter moves toward the outcome, saturating at 0 and 3. If ex_taken, target is also written.
  - Miss with ex_taken=1: allocate. Valid=1, tag written, target=ex_target, counter=2 (weakly taken).
  - Miss with ex_taken=0: no change.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
- Stats: stat_branches += 1 on each ex_valid. stat_misses += 1 on each mispredict. Both wrap modulo 2^32.
- ex_* inputs are ignored when ex_valid=0. No state changes.

## Timing
- Reset (async, rst_n=0): all valid=0, all counters=1, stats=0.
  - Resulting outputs: pred_taken=0, pred_target=if_pc+4, mispredict=0 (ex_valid permitting). Targets and tags need no reset.
- Lookup and mispredict/redirect_pc are zero-latency combinational.
- Table updates become visible to lookup in the cycle after the update edge.
- Same-index lookup and update in one cycle: lookup returns the pre-update entry. No bypass.
- Stats are visible one cycle after the counted event.
- Reset asserted mid-stream overrides any pending update in that cycle. After deassertion, the table behaves as cold.
- Aliasing (same index, different tag): a taken branch evicts the old entry on allocate. A not-taken miss leaves it intact.

## Test plan
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104. stat_branches=0, stat_misses=0.
- ex_valid=1, ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x80; stat_misses=1.
- Train 0x100 taken 3 times, then not-taken once -> counter 3→2, pred_taken stays 1. A second not-taken -> counter 1, pred_taken=0.
- Predicted taken to 0x80, resolved taken to 0x90 -> mispredict=1, redirect_pc=0x90. Entry target is updated to 0x90.
- ex_pc=0x200 not-taken, ex_pred_taken=0 (miss) -> mispredict=0, no allocation. stat_branches increments.
- Aliasing with ENTRIES=64: 0x100 and 0x200 share an index but differ in tag. Allocating 0x200 taken makes lookup of 0x100 miss. Assert rst_n low mid-update -> table cold and stats 0.
